// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory access unit: opcode and funct3
// constants, one-hot beat-size encodings, the controller FSM state
// type and small decode helpers used by both the top and the load
// extension logic.
package mem_pkg;

  localparam logic [6:0] LOAD_CODE  = 7'b0000011;
  localparam logic [6:0] STORE_CODE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [2:0] SEL_BYTE = 3'b001;
  localparam logic [2:0] SEL_HALF = 3'b010;
  localparam logic [2:0] SEL_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } mem_state_e;

  // Access size in bytes (1, 2 or 4); signedness bit does not affect size.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      3'd0, 3'd4: return 3'd1;
      3'd1, 3'd5: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal_load(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_store(input logic [2:0] funct3);
    case (funct3)
      F3_SB, F3_SH, F3_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // One-hot beat-size encoding for a beat of 1, 2 or 4 bytes.
  function automatic logic [2:0] sel_of(input logic [2:0] beat_bytes);
    case (beat_bytes)
      3'd1:    return SEL_BYTE;
      3'd2:    return SEL_HALF;
      default: return SEL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext
// Turns the assembled little-endian load accumulator into the final
// write-back value: sign-extends LB/LH, zero-extends LBU/LHU and passes
// LW through (sign-extended if XLEN is wider than 32).
// Ports:
//   acc_i    - assembled load bytes, byte 0 in bits [7:0]
//   funct3_i - load width/signedness
//   result_o - extended XLEN-wide result
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = acc_i;
    case (funct3_i)
      F3_LB:   result_o = XLEN'($signed(acc_i[7:0]));
      F3_LH:   result_o = XLEN'($signed(acc_i[15:0]));
      F3_LW:   result_o = XLEN'($signed(acc_i[31:0]));
      F3_LBU:  result_o = XLEN'(acc_i[7:0]);
      F3_LHU:  result_o = XLEN'(acc_i[15:0]);
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Pipeline MEM stage that performs loads and stores as a sequence of
// beats on a req/gnt/rvalid memory interface. Each access is split into
// min(SIZE, BUS_BYTES)-byte beats at consecutive (unaligned) addresses;
// load beats are gathered little-endian into an accumulator and then
// extended. The pipeline is stalled from the cycle the access is seen
// until the one-cycle DONE state that presents the result to WB.
// Non-memory (or illegal / invalid) instructions pass straight through.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   op_valid_i, op_i,
//   funct3_i                 - instruction valid, opcode, width/sign
//   mem_addr_i, reg_i        - effective address, store data
//   wd_i, wreg_i, wdata_i    - WB destination, write enable, ALU result
//   mem_req_o .. mem_data_o  - beat request to the memory controller
//   mem_gnt_i, mem_rvalid_i,
//   mem_data_i               - controller accept / read data return
//   stallreq_o               - stall request to the pipeline controller
//   wd_o, wreg_o, wdata_o    - write-back fields to WB
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid_i,
  input  logic [6:0]             op_i,
  input  logic [2:0]             funct3_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [XLEN-1:0]        reg_i,
  input  logic [4:0]             wd_i,
  input  logic                   wreg_i,
  input  logic [XLEN-1:0]        wdata_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [2:0]             mem_sel_o,
  output logic [8*BUS_BYTES-1:0] mem_data_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [8*BUS_BYTES-1:0] mem_data_i,
  output logic                   stallreq_o,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [XLEN-1:0]        wdata_o
);

  localparam int         BW    = 8 * BUS_BYTES;
  localparam logic [2:0] BUS_B = 3'(BUS_BYTES);

  mem_state_e        state_q, state_d;
  logic [2:0]        beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   sdata_q;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [2:0]        funct3_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              store_q;

  logic              start_load, start_store, start;
  logic [2:0]        size_q, beat_bytes;
  logic [5:0]        off_b;
  logic              last_beat;
  logic [XLEN-1:0]   store_shift;
  logic [BW-1:0]     lane_mask;
  logic [BW-1:0]     beat_wdata;
  logic [XLEN-1:0]   load_result;

  assign start_load  = op_valid_i && (op_i == LOAD_CODE)  && is_legal_load(funct3_i);
  assign start_store = op_valid_i && (op_i == STORE_CODE) && is_legal_store(funct3_i);
  assign start       = start_load || start_store;

  // Beat geometry of the latched access: beat width, byte offset of the
  // current beat, and whether the current beat is the final one.
  assign size_q     = size_of(funct3_q);
  assign beat_bytes = (size_q < BUS_B) ? size_q : BUS_B;
  assign off_b      = 6'(beat_q) * 6'(beat_bytes);
  assign last_beat  = (off_b + 6'(beat_bytes)) >= 6'(size_q);

  // Store lanes for the current beat, with lanes past the beat width zeroed
  // so a narrow access on a wide bus never drives stale bytes.
  assign store_shift = sdata_q >> {off_b, 3'b000};

  always_comb begin
    lane_mask = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      if (j < int'(beat_bytes)) lane_mask[8*j +: 8] = 8'hFF;
    end
  end

  assign beat_wdata = BW'(store_shift) & lane_mask;

  // Merge the returned beat into the accumulator at the current byte offset.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < XLEN/8; k++) begin
      for (int j = 0; j < BUS_BYTES; j++) begin
        if ((j < int'(beat_bytes)) && (k == int'(off_b) + j)) begin
          acc_d[8*k +: 8] = mem_data_i[8*j +: 8];
        end
      end
    end
  end

  mem_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .acc_i   (acc_q),
    .funct3_i(funct3_q),
    .result_o(load_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Latched access fields, beat counter and load accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      acc_q    <= '0;
      funct3_q <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            beat_q   <= '0;
            addr_q   <= mem_addr_i;
            sdata_q  <= reg_i;
            acc_q    <= '0;
            funct3_q <= funct3_i;
            wd_q     <= wd_i;
            wreg_q   <= wreg_i;
            store_q  <= start_store;
          end
        end
        ST_ISSUE: begin
          if (mem_gnt_i && store_q) beat_q <= beat_q + 3'd1;
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            acc_q  <= acc_d;
            beat_q <= beat_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_gnt_i) begin
          if (!store_q)      state_d = ST_WAIT;
          else if (last_beat) state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) state_d = last_beat ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; everything is held at zero while rst is
  // asserted so the abandoned access cannot leak a request or a write-back.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_sel_o  = '0;
    mem_data_o = '0;
    stallreq_o = 1'b0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          stallreq_o = start;
          if (!start) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ST_ISSUE: begin
          stallreq_o = 1'b1;
          mem_req_o  = 1'b1;
          mem_we_o   = store_q;
          mem_addr_o = addr_q + ADDR_W'(off_b);
          mem_sel_o  = sel_of(beat_bytes);
          mem_data_o = store_q ? beat_wdata : '0;
        end
        ST_WAIT: begin
          stallreq_o = 1'b1;
        end
        ST_DONE: begin
          wd_o    = wd_q;
          wreg_o  = wreg_q;
          wdata_o = store_q ? wdata_i : load_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit. Three instances share the
// instruction inputs and differ in BUS_BYTES (1, 2, 4); each has its own
// op_valid and memory handshake. The BUS_BYTES=1 instance is served by a
// small byte-memory responder (gnt on the cycle of the request, rvalid
// one cycle later); the others are driven by hand.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [6:0]  op_i     = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] reg_i    = '0;
  logic [4:0]  wd_i     = '0;
  logic        wreg_i   = 1'b0;
  logic [31:0] wdata_i  = '0;

  logic valid1 = 1'b0, valid2 = 1'b0, valid4 = 1'b0;

  // BUS_BYTES = 1 instance
  logic        req1, we1, stall1, wreg1;
  logic [31:0] addr1, wdata1;
  logic [2:0]  sel1;
  logic [7:0]  data1;
  logic [4:0]  wd1;
  logic        gnt1 = 1'b0, rvalid1 = 1'b0;
  logic [7:0]  rdata1 = '0;

  // BUS_BYTES = 2 instance
  logic        req2, we2, stall2, wreg2;
  logic [31:0] addr2, wdata2;
  logic [2:0]  sel2;
  logic [15:0] data2;
  logic [4:0]  wd2;
  logic        gnt2 = 1'b0, rvalid2 = 1'b0;
  logic [15:0] rdata2 = '0;

  // BUS_BYTES = 4 instance
  logic        req4, we4, stall4, wreg4;
  logic [31:0] addr4, wdata4;
  logic [2:0]  sel4;
  logic [31:0] data4;
  logic [4:0]  wd4;
  logic        gnt4 = 1'b0, rvalid4 = 1'b0;
  logic [31:0] rdata4 = '0;

  int check_count = 0;
  int fail_count  = 0;

  logic [7:0]  mem1 [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [2:0]  log_sel  [$];
  logic        resp_pending = 1'b0;
  logic [31:0] pend_addr = '0;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(1)) u_b1 (
    .clk(clk), .rst(rst), .op_valid_i(valid1), .op_i(op_i), .funct3_i(funct3_i),
    .mem_addr_i(mem_addr_i), .reg_i(reg_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_req_o(req1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_sel_o(sel1), .mem_data_o(data1),
    .mem_gnt_i(gnt1), .mem_rvalid_i(rvalid1), .mem_data_i(rdata1),
    .stallreq_o(stall1), .wd_o(wd1), .wreg_o(wreg1), .wdata_o(wdata1)
  );

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(2)) u_b2 (
    .clk(clk), .rst(rst), .op_valid_i(valid2), .op_i(op_i), .funct3_i(funct3_i),
    .mem_addr_i(mem_addr_i), .reg_i(reg_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_req_o(req2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_sel_o(sel2), .mem_data_o(data2),
    .mem_gnt_i(gnt2), .mem_rvalid_i(rvalid2), .mem_data_i(rdata2),
    .stallreq_o(stall2), .wd_o(wd2), .wreg_o(wreg2), .wdata_o(wdata2)
  );

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(4)) u_b4 (
    .clk(clk), .rst(rst), .op_valid_i(valid4), .op_i(op_i), .funct3_i(funct3_i),
    .mem_addr_i(mem_addr_i), .reg_i(reg_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_req_o(req4), .mem_we_o(we4), .mem_addr_o(addr4), .mem_sel_o(sel4), .mem_data_o(data4),
    .mem_gnt_i(gnt4), .mem_rvalid_i(rvalid4), .mem_data_i(rdata4),
    .stallreq_o(stall4), .wd_o(wd4), .wreg_o(wreg4), .wdata_o(wdata4)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] memByte(input logic [31:0] a);
    return mem1.exists(a) ? mem1[a] : 8'h00;
  endfunction

  // Byte-memory responder for the BUS_BYTES=1 instance.
  always @(negedge clk) begin
    gnt1    = 1'b0;
    rvalid1 = 1'b0;
    rdata1  = 8'h00;
    if (rst) begin
      resp_pending = 1'b0;
    end else if (resp_pending) begin
      rvalid1      = 1'b1;
      rdata1       = memByte(pend_addr);
      resp_pending = 1'b0;
    end else if (req1) begin
      gnt1 = 1'b1;
      log_addr.push_back(addr1);
      log_sel.push_back(sel1);
      if (!we1) begin
        resp_pending = 1'b1;
        pend_addr    = addr1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rdat, input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdat);
    op_i       = op;
    funct3_i   = f3;
    mem_addr_i = addr;
    reg_i      = rdat;
    wd_i       = wd;
    wreg_i     = wreg;
    wdata_i    = wdat;
  endtask

  // Issue one instruction to the BUS_BYTES=1 instance and follow it until
  // stall drops, returning stall length and the write-back seen then.
  task automatic runB1(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdat, output int stalls, output logic [31:0] res,
                       output logic res_wreg, output logic res_req);
    @(posedge clk); #1;
    log_addr.delete();
    log_sel.delete();
    applyStimulus(op, f3, addr, 32'h0, 5'd7, 1'b1, wdat);
    valid1 = 1'b1;
    stalls = 0;
    #1;
    while (stall1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      valid1 = 1'b0;
      #1;
    end
    res      = wdata1;
    res_wreg = wreg1;
    res_req  = req1;
    valid1   = 1'b0;
  endtask

  initial begin
    int          stalls;
    int          n;
    int          req_seen;
    logic [31:0] res;
    logic        res_wreg, res_req;

    mem1[32'h1003] = 8'h11;
    mem1[32'h1004] = 8'h22;
    mem1[32'h1005] = 8'h33;
    mem1[32'h1006] = 8'h44;
    mem1[32'h0020] = 8'h80;

    // Reset with a live load on the inputs: everything must stay quiet.
    rst = 1'b1;
    applyStimulus(LOAD_CODE, F3_LW, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h77);
    valid1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall1", stall1, 0);
    checkOutput("rst_req1", req1, 0);
    checkOutput("rst_wdata1", wdata1, 0);
    checkOutput("rst_wreg1", wreg1, 0);
    checkOutput("rst_wdata4", wdata4, 0);
    valid1 = 1'b0;
    applyStimulus('0, '0, '0, '0, '0, 1'b0, '0);
    rst = 1'b0;

    // LW @0x1003 over a byte bus: four unaligned single-byte beats.
    runB1(LOAD_CODE, F3_LW, 32'h1003, 32'h0, stalls, res, res_wreg, res_req);
    checkOutput("lw_stall_cycles", stalls, 9);
    checkOutput("lw_wdata", res, 32'h44332211);
    checkOutput("lw_wreg", res_wreg, 1);
    checkOutput("lw_beats", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("lw_beat%0d_addr", i),
                  (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF, 32'h1003 + i);
      checkOutput($sformatf("lw_beat%0d_sel", i),
                  (i < log_sel.size()) ? log_sel[i] : 3'b111, 3'b001);
    end

    // LB / LBU of 0x80.
    runB1(LOAD_CODE, F3_LB, 32'h20, 32'h0, stalls, res, res_wreg, res_req);
    checkOutput("lb_stall_cycles", stalls, 3);
    checkOutput("lb_wdata", res, 32'hFFFFFF80);
    runB1(LOAD_CODE, F3_LBU, 32'h20, 32'h0, stalls, res, res_wreg, res_req);
    checkOutput("lbu_wdata", res, 32'h00000080);
    checkOutput("lbu_beats", log_addr.size(), 1);

    // Illegal load width: pass-through, no access.
    runB1(LOAD_CODE, 3'd3, 32'h20, 32'hCAFE0001, stalls, res, res_wreg, res_req);
    checkOutput("f3_3_stall", stalls, 0);
    checkOutput("f3_3_wdata", res, 32'hCAFE0001);
    checkOutput("f3_3_req", res_req, 0);
    @(posedge clk); #1;
    checkOutput("f3_3_no_beat", log_addr.size(), 0);

    // SH on a 2-byte bus with gnt withheld for three cycles.
    @(posedge clk); #1;
    applyStimulus(STORE_CODE, F3_SH, 32'h40, 32'hABCD1234, 5'd0, 1'b0, 32'h5555);
    valid2 = 1'b1;
    stalls = 0;
    #1;
    if (stall2) stalls++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      valid2 = 1'b0;
      if (stall2) stalls++;
      checkOutput($sformatf("sh_req_c%0d", k), req2, 1);
      checkOutput($sformatf("sh_addr_c%0d", k), addr2, 32'h40);
      checkOutput($sformatf("sh_data_c%0d", k), data2, 16'h1234);
      if (k == 0) begin
        checkOutput("sh_we", we2, 1);
        checkOutput("sh_sel", sel2, 3'b010);
      end
      if (k == 3) gnt2 = 1'b1;
    end
    @(posedge clk); #1;
    gnt2 = 1'b0;
    checkOutput("sh_done_stall", stall2, 0);
    checkOutput("sh_done_req", req2, 0);
    checkOutput("sh_done_wreg", wreg2, 0);
    checkOutput("sh_done_wdata", wdata2, 32'h5555);
    checkOutput("sh_stall_cycles", stalls, 5);
    @(posedge clk); #1;
    checkOutput("sh_one_beat", req2, 0);

    // ADD-type op on the 4-byte instance: same-cycle pass-through.
    applyStimulus(7'b0110011, 3'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h5);
    valid4 = 1'b1;
    #1;
    checkOutput("add_stall", stall4, 0);
    checkOutput("add_req", req4, 0);
    checkOutput("add_wdata", wdata4, 32'h5);
    checkOutput("add_wd", wd4, 5'd3);
    checkOutput("add_wreg", wreg4, 1);

    // LW on the 4-byte instance: single beat, three stall cycles.
    @(posedge clk); #1;
    applyStimulus(LOAD_CODE, F3_LW, 32'h200, 32'h0, 5'd9, 1'b1, 32'h0);
    valid4 = 1'b1;
    stalls = 0;
    #1;
    if (stall4) stalls++;
    @(posedge clk); #1;
    valid4 = 1'b0;
    if (stall4) stalls++;
    checkOutput("lw4_req", req4, 1);
    checkOutput("lw4_sel", sel4, 3'b100);
    checkOutput("lw4_addr", addr4, 32'h200);
    gnt4 = 1'b1;
    @(posedge clk); #1;
    gnt4 = 1'b0;
    if (stall4) stalls++;
    checkOutput("lw4_wait_req", req4, 0);
    rvalid4 = 1'b1;
    rdata4  = 32'hDEADBEEF;
    @(posedge clk); #1;
    rvalid4 = 1'b0;
    checkOutput("lw4_done_stall", stall4, 0);
    checkOutput("lw4_wdata", wdata4, 32'hDEADBEEF);
    checkOutput("lw4_wd", wd4, 5'd9);
    checkOutput("lw4_stall_cycles", stalls, 3);

    // Reset in WAIT after the second beat of a byte-bus LW.
    @(posedge clk); #1;
    log_addr.delete();
    log_sel.delete();
    applyStimulus(LOAD_CODE, F3_LW, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0);
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    n = 0;
    while (log_addr.size() < 2 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("rstmid_reached_beat2", log_addr.size(), 2);
    @(posedge clk); #1;
    checkOutput("rstmid_wait_stall", stall1, 1);
    checkOutput("rstmid_wait_req", req1, 0);
    rst = 1'b1;
    applyStimulus(LOAD_CODE, F3_LW, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h99);
    @(posedge clk); #1;
    checkOutput("rstmid_req", req1, 0);
    checkOutput("rstmid_stall", stall1, 0);
    checkOutput("rstmid_wdata", wdata1, 0);
    checkOutput("rstmid_wreg", wreg1, 0);
    checkOutput("rstmid_addr", addr1, 0);
    rst = 1'b0;
    applyStimulus('0, '0, '0, '0, '0, 1'b0, '0);
    req_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (req1) req_seen++;
    end
    checkOutput("rstmid_no_req", req_seen, 0);
    checkOutput("rstmid_no_beats", log_addr.size(), 2);

    // A fresh access after the abandoned one starts clean.
    runB1(LOAD_CODE, F3_LBU, 32'h20, 32'h0, stalls, res, res_wreg, res_req);
    checkOutput("post_rst_stall", stalls, 3);
    checkOutput("post_rst_wdata", res, 32'h00000080);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline MEM stage.
- Runs loads and stores as multi-beat transactions to the memory controller through a req/gnt/rvalid handshake. It tracks its own beat count, so the pipeline no longer loops a cnt_i/cnt_o counter.
- Assembles load data little-endian and sign- or zero-extends it.
- Asserts stallreq_o until the access completes. Non-memory instructions pass straight to WB.

Parameters:
- XLEN, 32, register/data width.
- ADDR_W, 32, memory address width.
- BUS_BYTES, 1, bytes per memory beat; legal values 1, 2, 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- op_valid_i  in  1  MEM-stage instruction valid
- op_i  in  7  opcode; LOAD_CODE and STORE_CODE are acted on
- funct3_i  in  3  access width and signedness
- mem_addr_i  in  ADDR_W  effective address
- reg_i  in  XLEN  store data
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  XLEN  ALU result for non-load instructions
- mem_req_o  out  1  beat request
- mem_we_o  out  1  beat is a write
- mem_addr_o  out  ADDR_W  beat address
- mem_sel_o  out  3  beat size, one-hot: 001 = 1 byte, 010 = 2 bytes, 100 = 4 bytes
- mem_data_o  out  8*BUS_BYTES  write data for the beat
- mem_gnt_i  in  1  controller accepted the request this cycle
- mem_rvalid_i  in  1  read data valid
- mem_data_i  in  8*BUS_BYTES  read data
- stallreq_o  out  1  stall request to the pipeline controller
- wd_o  out  5  destination register to WB
- wreg_o  out  1  register write enable to WB
- wdata_o  out  XLEN  write-back data to WB

Behaviour:
- Access size: SIZE = 1/2/4 bytes for funct3[1:0] = 0/1/2.
  - Beat size: BEAT = min(SIZE, BUS_BYTES).
  - Beat count: NB = SIZE/BEAT.
  - mem_sel_o encodes BEAT.
- Legal accesses:
  - Loads: funct3 = LB, LH, LW, LBU, LHU.
  - Stores: funct3 = SB, SH, SW.
  - Any other funct3, or !op_valid_i: no access, no stall, wd_o/wreg_o/wdata_o = inputs.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - Beat counter width: 3 bits.
  - Latched fields: addr, store data, funct3, wd, wreg, load accumulator (XLEN).
- IDLE:
  - Non-memory op: combinational pass-through.
  - Legal memory op: stallreq_o = 1 in the same cycle, latch all fields, beat = 0, next state ISSUE.
- ISSUE:
  - Drive mem_req_o = 1.
  - mem_addr_o = addr + beat*BEAT, with no alignment requirement.
  - mem_we_o = store; mem_data_o = store_data byte lanes [beat*BEAT +: BEAT].
  - Hold all request outputs stable until mem_gnt_i.
  - On gnt for a store: beat++; next state DONE if this was the last beat, else stay in ISSUE.
  - On gnt for a load: next state WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: write mem_data_i into accumulator lanes [beat*BEAT +: BEAT], beat++; next state DONE if last beat, else ISSUE.
  - mem_rvalid_i is sampled only in WAIT. The controller returns rvalid at least one cycle after gnt.
- DONE (one cycle):
  - stallreq_o = 0; wd_o and wreg_o from latch.
  - Load: wdata_o = accumulator low SIZE bytes, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Store: wdata_o = wdata_i and wreg_o = latched wreg (0 expected).
  - Next state IDLE, so the following instruction is evaluated the next cycle.
- stallreq_o is 1 in the IDLE detect cycle, in ISSUE and in WAIT, and 0 in DONE.
- Latency for an LW with BUS_BYTES = 1, immediate gnt and rvalid one cycle after gnt:
  - stall high for 1 + 4*2 = 9 cycles; result presented in cycle 10.
  - With BUS_BYTES = 4, stall lasts 3 cycles.
- Outputs outside ISSUE: mem_req_o, mem_we_o, mem_addr_o, mem_sel_o and mem_data_o are all 0.
- Reset: rst in any state (including mid-transaction) forces IDLE on the next edge, clears the counter and accumulator, and zeros all outputs. The pending access is abandoned with no further beats. Outputs are registered or state-decoded, so none glitch during reset.
- gnt or rvalid arriving in an unexpected state is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package (mem_pkg):
  - LOAD_CODE, STORE_CODE and all funct3 constants.
  - SEL encodings 001/010/100.
  - FSM state enum.
  - size_of(funct3) function.
- One combinational sub-module, mem_load_ext: accumulator + funct3 -> extended XLEN result.

Test Plan:
- BUS_BYTES = 1, LW @0x1003, memory bytes 0x1003..0x1006 = 11 22 33 44:
  - 4 beats at 0x1003..0x1006, each with sel 001.
  - Stall for 9 cycles, then wdata_o = 0x44332211 with wreg_o = 1.
- BUS_BYTES = 1, LB @0x20 returning 0x80 -> wdata_o = 0xFFFFFF80.
- BUS_BYTES = 1, LBU @0x20 returning 0x80 -> wdata_o = 0x00000080.
- BUS_BYTES = 2, SH @0x40 with reg_i = 0xABCD1234:
  - Exactly one beat: we = 1, sel 010, data 0x1234.
  - With gnt held low for 3 cycles, request fields stay stable and stall is extended 3 cycles.
- BUS_BYTES = 4, ADD-type op (op_i not load/store) with wdata_i = 0x5 -> same-cycle pass-through, stallreq_o = 0, mem_req_o = 0.
- BUS_BYTES = 1, LW with rst asserted while in WAIT after beat 2 -> next cycle IDLE, all outputs 0, no further mem_req_o.
- BUS_BYTES = 1, funct3 = 3 load -> no access, no stall, wdata_o = wdata_i.
